// File: rtl/teclado_event_ctrl.sv
// Front-panel button controller: sync + debounce 7 buttons, queue press codes, PicoBlaze interrupt/readback.
// Optional auto-repeat on aumenta/disminuye is compiled in with TECLADO_AUTOREPEAT_EN.
module teclado_event_ctrl #(
    parameter int           DEBOUNCE_CYCLES = 500000,
    parameter int           FIFO_DEPTH      = 4,
    parameter logic [7:0]   PORT_EVENT      = 8'h03,
    parameter logic [7:0]   PORT_STATUS     = 8'h07,
    parameter int           REPEAT_DELAY    = 25000000,
    parameter int           REPEAT_PERIOD   = 10000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  btn,
    input  logic [7:0]  port_id,
    input  logic        read_strobe,
    output logic [7:0]  in_port,
    output logic        interrupt,
    input  logic        interrupt_ack
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DW-1:0] LP_DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

    logic [6:0]    r_sync1, r_sync2, r_stable, r_stable_d, r_pending;
    logic [DW-1:0] r_db_cnt [7];
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_in_port;
    state_t        r_state, w_state_nxt;

    logic [6:0] w_rise, w_rep_set, w_push_oh;
    logic [2:0] w_push_idx;
    logic [3:0] w_cnt_ext;
    logic       w_full, w_empty, w_push, w_pop, w_ev_rd, w_interrupt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int i = 0; i < 7; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1    <= btn;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            for (int i = 0; i < 7; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == LP_DB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_rise = r_stable & ~r_stable_d;

`ifdef TECLADO_AUTOREPEAT_EN
    logic [31:0] r_rep_cnt [2];
    logic [1:0]  r_rep_armed;

    always_comb begin
        w_rep_set = '0;
        for (int i = 0; i < 2; i++)
            w_rep_set[i] = r_stable[i] && (r_rep_armed[i] ? (r_rep_cnt[i] == 32'(REPEAT_PERIOD - 1))
                                                          : (r_rep_cnt[i] == 32'(REPEAT_DELAY - 1)));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset || !r_stable[i]) begin
                r_rep_cnt[i]   <= '0;
                r_rep_armed[i] <= 1'b0;
            end else if (w_rep_set[i]) begin
                r_rep_cnt[i]   <= '0;
                r_rep_armed[i] <= 1'b1;
            end else begin
                r_rep_cnt[i]   <= r_rep_cnt[i] + 1'b1;
            end
        end
    end
`else
    assign w_rep_set = '0;
`endif

    // Lowest pending index wins; a held bit just waits while the queue is full.
    always_comb begin
        w_push_idx = '0;
        for (int i = 6; i >= 0; i--)
            if (r_pending[i]) w_push_idx = 3'(i);
    end

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = (|r_pending) && !w_full;
    assign w_push_oh = w_push ? (7'b1 << w_push_idx) : 7'b0;
    assign w_ev_rd   = read_strobe && (port_id == PORT_EVENT);
    assign w_pop     = w_ev_rd && !w_empty;
    assign w_cnt_ext = 4'(r_count);

    always_ff @(posedge clk) begin
        if (w_push && !reset) r_mem[r_wr_ptr] <= 8'h04 + {5'b0, w_push_idx};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_in_port <= '0;
        end else begin
            r_pending <= (r_pending & ~w_push_oh) | w_rise | w_rep_set;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (port_id == PORT_EVENT)
                r_in_port <= w_empty ? 8'h00 : r_mem[r_rd_ptr];
            else if (port_id == PORT_STATUS)
                r_in_port <= {w_full, 4'b0000, w_cnt_ext[2:0]};
            else
                r_in_port <= 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (!w_empty)     w_state_nxt = S_REQ;
            S_REQ:     if (interrupt_ack) w_state_nxt = S_SERVICE;
            S_SERVICE: if (w_ev_rd)      w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_interrupt = (r_state == S_REQ);
    end

    assign interrupt = w_interrupt;
    assign in_port   = r_in_port;
endmodule

// File: tb/tb_teclado_event_ctrl.sv
// Bench for teclado_event_ctrl: directed scenarios plus a randomized press/read mix against an event-queue model.
module tb_teclado_event_ctrl;
    localparam int         D  = 4;
    localparam logic [7:0] PE = 8'h03;
    localparam logic [7:0] PS = 8'h07;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] btn = '0;
    logic [7:0] port_id = '0;
    logic       read_strobe = 1'b0;
    logic       interrupt_ack = 1'b0;
    logic [7:0] in_port;
    logic       interrupt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] q_ev[$];
    logic [6:0] m_pend = '0;

    teclado_event_ctrl #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .btn(btn), .port_id(port_id), .read_strobe(read_strobe),
        .in_port(in_port), .interrupt(interrupt), .interrupt_ack(interrupt_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Each press becomes a pending flag; flags drain lowest-first into a 4-deep queue.
    task automatic model_fill();
        while (m_pend != 0 && q_ev.size() < 4) begin
            for (int i = 0; i < 7; i++) begin
                if (m_pend[i]) begin
                    q_ev.push_back(8'(4 + i));
                    m_pend[i] = 1'b0;
                    break;
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {(q_ev.size() == 4), 4'b0000, 3'(q_ev.size())};
    endfunction

    task automatic do_reset(input int n);
        reset = 1'b1; btn = '0; read_strobe = 1'b0; interrupt_ack = 1'b0;
        tick(n);
        reset = 1'b0;
        q_ev.delete();
        m_pend = '0;
    endtask

    task automatic press(input logic [6:0] m);
        btn = m;
        tick(20);
        btn = '0;
        tick(20);
        m_pend |= m;
        model_fill();
    endtask

    task automatic check_status(input string name);
        port_id = PS;
        tick(2);
        n_cmp++;
        if (in_port !== exp_status()) begin
            n_bad++;
            $display("FAIL %s: in_port=%h expected %h", name, in_port, exp_status());
        end
    endtask

    task automatic read_event(input string name);
        logic [7:0] exp;
        port_id = PE;
        tick(2);
        exp = (q_ev.size() != 0) ? q_ev[0] : 8'h00;
        n_cmp++;
        if (in_port !== exp) begin
            n_bad++;
            $display("FAIL %s: in_port=%h expected %h", name, in_port, exp);
        end
        read_strobe = 1'b1;
        tick(1);
        read_strobe = 1'b0;
        if (q_ev.size() != 0) void'(q_ev.pop_front());
        model_fill();
        tick(3);
    endtask

    task automatic check_irq(input string name, input logic exp);
        n_cmp++;
        if (interrupt !== exp) begin
            n_bad++;
            $display("FAIL %s: interrupt=%b expected %b", name, interrupt, exp);
        end
    endtask

    task automatic pulse_ack();
        interrupt_ack = 1'b1;
        tick(1);
        interrupt_ack = 1'b0;
    endtask

    task automatic test_reset();
        port_id = PS;
        do_reset(2);
        check_irq("reset_irq", 1'b0);
        n_cmp++;
        if (in_port !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_in_port: in_port=%h expected 00", in_port);
        end
        tick(1);
        n_cmp++;
        if (in_port !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_status: in_port=%h expected 00", in_port);
        end
    endtask

    task automatic test_clean_press();
        int lat;
        do_reset(2);
        port_id = PS;
        btn = 7'h01;
        lat = 0;
        while (interrupt !== 1'b1 && lat < 30) begin
            tick(1);
            lat++;
        end
        // 2 sync + D debounce + 1 edge + 1 push, then one more for the interrupt.
        n_cmp++;
        if (lat != 2 + D + 1 + 1 + 1) begin
            n_bad++;
            $display("FAIL press_latency: cycles=%0d expected %0d", lat, 2 + D + 3);
        end
        n_cmp++;
        if (in_port !== 8'h01) begin
            n_bad++;
            $display("FAIL press_status_at_irq: in_port=%h expected 01", in_port);
        end
        tick(20 - lat);
        btn = '0;
        tick(10);
        m_pend |= 7'h01;
        model_fill();
        check_irq("press_irq_held", 1'b1);
        pulse_ack();
        check_irq("press_irq_ack", 1'b0);
        read_event("press_read");
        check_irq("press_no_reraise", 1'b0);
        check_status("press_status_after");
    endtask

    task automatic test_bounce();
        do_reset(2);
        btn = 7'h02; tick(3);
        btn = '0;    tick(2);
        btn = 7'h02; tick(3);
        btn = '0;    tick(20);
        check_irq("bounce_irq", 1'b0);
        check_status("bounce_status");
    endtask

    task automatic test_simultaneous();
        do_reset(2);
        press(7'h44);
        check_status("simul_status");
        check_irq("simul_irq", 1'b1);
        pulse_ack();
        check_irq("simul_irq_ack", 1'b0);
        read_event("simul_read0");
        check_irq("simul_reraise", 1'b1);
        read_event("simul_read1");
        read_event("simul_read_empty");
        check_status("simul_status_end");
    endtask

    task automatic test_overflow();
        do_reset(2);
        for (int i = 0; i < 5; i++) press(7'(1 << i));
        check_status("ovf_status_full");
        read_event("ovf_read0");
        check_status("ovf_status_refill");
        for (int i = 1; i < 5; i++) read_event("ovf_read_rest");
        check_status("ovf_status_end");
    endtask

    task automatic test_reset_mid_service();
        do_reset(2);
        press(7'h07);
        check_irq("midrst_irq_before", 1'b1);
        port_id = PS;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        q_ev.delete();
        m_pend = '0;
        check_irq("midrst_irq_after", 1'b0);
        n_cmp++;
        if (in_port !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_in_port: in_port=%h expected 00", in_port);
        end
        tick(5);
        check_irq("midrst_no_reraise", 1'b0);
        check_status("midrst_status");
    endtask

    task automatic test_random();
        do_reset(2);
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 9) < 6) begin
                press(7'($urandom_range(1, 127)));
            end else begin
                check_status("rand_status");
                read_event("rand_read");
            end
            if ($urandom_range(0, 3) == 0) pulse_ack();
        end
        for (int k = 0; k < 12 && (q_ev.size() != 0 || m_pend != 0); k++)
            read_event("rand_drain");
        check_status("rand_status_end");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_overflow();
        test_reset_mid_service();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
